// File: rtl/ifetch_stage.sv
// Purpose: RISC-V instruction fetch. Owns the PC, keeps at most one word fetch in flight, and loads the IF/ID register.
// Latency: a request issues one cycle after IF/ID frees. IF/ID loads on the edge where the response arrives. Best case is 2 cycles per instruction.
// Backpressure: no request issues unless IF/ID is free. imem_req_ready low holds the request with a stable address. id_ready low holds IF/ID.
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   fetch request handshake (word-aligned address)
//   imem_rsp_valid, imem_rsp_data     fetch response (at least 1 cycle after acceptance)
//   redirect_valid, redirect_pc       taken branch/jump from execute (1-cycle pulse)
//   id_valid/ready, id_inst, id_pc    IF/ID register towards decode
//   fetch_misalign                    only with FETCH_MISALIGN_EN: misaligned redirect seen
//
// Build option: define FETCH_MISALIGN_EN to trap misaligned redirect targets in an ERR state.
// Without it, redirect_pc[1:0] is forced to zero.
module ifetch_stage #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [N-1:0] id_inst,
    output logic [N-1:0] id_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic         fetch_misalign
`endif
);

    localparam logic [N-1:0] NOP_INST   = N'(32'h0000_0013);
    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
`ifdef FETCH_MISALIGN_EN
        ,
        ST_ERR  = 2'd3
`endif
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         id_valid_q, id_valid_d;
    logic [N-1:0] id_inst_q, id_pc_q;
    logic         load;
    logic         if_free;
    logic         issue;
    logic         accept;
    logic [N-1:0] redirect_tgt;
`ifdef FETCH_MISALIGN_EN
    logic         misalign_q, misalign_d;
`endif

    // IF/ID counts as free if it is empty now, or if decode takes it this cycle.
    assign if_free = !id_valid_q || id_ready;

    // The request is gated by if_free. Once REQ sees IF/ID free, it stays free
    // because nothing loads while in REQ. So a presented request is never withdrawn.
    // Gating with rst stops a request from being accepted during reset.
    assign issue  = (state_q == ST_REQ) && if_free && !rst;
    assign accept = issue && imem_req_ready;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        id_valid_d = id_valid_q;
        load       = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (if_free) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        load    = 1'b1;
                        // IF/ID is empty while waiting, so id_ready here means decode
                        // will take the new word on the next edge.
                        state_d = id_ready ? ST_REQ : ST_IDLE;
                    end
                end
            end
`ifdef FETCH_MISALIGN_EN
            ST_ERR: begin
                // A fetch may still have been in flight when ERR was entered.
                // Its response clears kill here.
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            id_valid_d = 1'b1;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end

        // A redirect overrides the normal flow, including a same-cycle response.
        if (redirect_valid) begin
            load       = 1'b0;
            id_valid_d = 1'b0;
            pc_d       = redirect_tgt;
            case (state_q)
                ST_REQ: begin
                    // A kill is only needed if a request leaves on this very edge.
                    // Otherwise the new address is presented instead.
                    state_d = accept ? ST_WAIT : ST_REQ;
                    kill_d  = accept;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
`ifdef FETCH_MISALIGN_EN
                ST_ERR: begin
                    // If a stale response is still due, wait for it and drop it
                    // before fetching the new target.
                    kill_d  = kill_q && !imem_rsp_valid;
                    state_d = (kill_q && !imem_rsp_valid) ? ST_WAIT : ST_REQ;
                end
`endif
                default: begin
                    state_d = ST_REQ;
                end
            endcase
`ifdef FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                pc_d       = redirect_pc;
                misalign_d = 1'b1;
                state_d    = ST_ERR;
            end else begin
                misalign_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= {N{1'b0}};
`ifdef FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            id_valid_q <= id_valid_d;
`ifdef FETCH_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
            if (load) begin
                id_inst_q <= imem_rsp_data;
                // pc already advanced past the word that is returning.
                id_pc_q   <= pc_q - PC_STEP;
            end
        end
    end

    assign imem_req_valid = issue;
    assign imem_addr      = pc_q & ALIGN_MASK;
    assign id_valid       = id_valid_q;
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;
`ifdef FETCH_MISALIGN_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Purpose: directed bench for ifetch_stage. A cycle-by-cycle vector table is followed by hand sequences.
// Latency: inputs are driven on the falling edge, and outputs are sampled 1 time unit later.
// Backpressure: imem_req_ready and id_ready are driven directly by the vectors and tasks.
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00a0_0113;
    localparam logic [31:0] I2  = 32'h00b0_0193;
    localparam logic [31:0] I3  = 32'h00c0_0213;
    localparam logic [31:0] I4  = 32'h00d0_0293;
    localparam logic [31:0] BAD = 32'hdead_beef;
    localparam int          NV  = 21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic idr, input logic e_req, input logic [31:0] e_addr,
                                input logic e_idv, input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.idr = idr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_idv = e_idv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address, and lets it be accepted.
    task automatic issue(input string name, input logic [31:0] exp_addr);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            imem_req_ready = 1'b1;
            #1;
            if (imem_req_valid) begin
                seen = 1'b1;
                check({name, "_addr"}, imem_addr, exp_addr);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no request within 8 cycles, expected addr %08h", name, exp_addr);
        end
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1;
    endtask

    initial begin
        //                rst rdy rv rd   idr | req addr   idv inst pc
        vecs[0]  = mk(1, 0, 0, 0,  0,  0, 32'h00, 0, NOP, 32'h00);
        vecs[1]  = mk(0, 1, 0, 0,  1,  0, 32'h00, 0, NOP, 32'h00);
        vecs[2]  = mk(0, 1, 0, 0,  1,  1, 32'h00, 0, NOP, 32'h00);
        vecs[3]  = mk(0, 1, 1, I0, 1,  0, 32'h04, 0, NOP, 32'h00);
        vecs[4]  = mk(0, 1, 0, 0,  1,  1, 32'h04, 1, I0,  32'h00);
        vecs[5]  = mk(0, 1, 1, I1, 1,  0, 32'h08, 0, I0,  32'h00);
        vecs[6]  = mk(0, 1, 0, 0,  1,  1, 32'h08, 1, I1,  32'h04);
        vecs[7]  = mk(0, 1, 1, I2, 1,  0, 32'h0c, 0, I1,  32'h04);
        vecs[8]  = mk(0, 1, 0, 0,  1,  1, 32'h0c, 1, I2,  32'h08);
        vecs[9]  = mk(0, 1, 1, I3, 0,  0, 32'h10, 0, I2,  32'h08);
        vecs[10] = mk(0, 1, 0, 0,  0,  0, 32'h10, 1, I3,  32'h0c);
        vecs[11] = mk(0, 1, 0, 0,  0,  0, 32'h10, 1, I3,  32'h0c);
        vecs[12] = mk(0, 1, 0, 0,  0,  0, 32'h10, 1, I3,  32'h0c);
        vecs[13] = mk(0, 1, 0, 0,  0,  0, 32'h10, 1, I3,  32'h0c);
        vecs[14] = mk(0, 1, 0, 0,  0,  0, 32'h10, 1, I3,  32'h0c);
        vecs[15] = mk(0, 1, 0, 0,  1,  0, 32'h10, 1, I3,  32'h0c);
        vecs[16] = mk(0, 1, 0, 0,  1,  1, 32'h10, 0, I3,  32'h0c);
        vecs[17] = mk(0, 1, 1, I4, 1,  0, 32'h14, 0, I3,  32'h0c);
        vecs[18] = mk(0, 0, 0, 0,  1,  1, 32'h14, 1, I4,  32'h10);
        vecs[19] = mk(0, 1, 0, 0,  1,  1, 32'h14, 0, I4,  32'h10);
        vecs[20] = mk(0, 1, 0, 0,  1,  0, 32'h18, 0, I4,  32'h10);

        // Reset, first fetch, streaming, decode stall, imem_req_ready stall.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rd;
            id_ready       = vecs[i].idr;
            redirect_valid = 1'b0;
            #1;
            check($sformatf("v%0d_req", i),  {31'h0, imem_req_valid}, {31'h0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_idv", i),  {31'h0, id_valid}, {31'h0, vecs[i].e_idv});
            check($sformatf("v%0d_inst", i), id_inst, vecs[i].e_inst);
            check($sformatf("v%0d_pc", i),   id_pc, vecs[i].e_pc);
        end

        // Redirect while waiting: the in-flight response is killed.
        do_reset();
        id_ready = 1'b1;
        issue("b0", 32'h0);
        respond(32'h0010_0093);
        issue("b1", 32'h4);
        respond(32'h0020_0093);
        issue("b2", 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("b_flush_idv", {31'h0, id_valid}, 32'h0);
        check("b_kill_noreq", {31'h0, imem_req_valid}, 32'h0);
        respond(BAD);
        check("b_drop_idv", {31'h0, id_valid}, 32'h0);
        issue("b_tgt", 32'h100);
        respond(32'h0030_0093);
        check("b_new_idv", {31'h0, id_valid}, 32'h1);
        check("b_new_pc", id_pc, 32'h100);
        check("b_new_inst", id_inst, 32'h0030_0093);

        // Redirect in the same cycle as the response.
        do_reset();
        id_ready = 1'b1;
        issue("c0", 32'h0);
        respond(32'h0040_0093);
        issue("c1", 32'h4);
        imem_rsp_valid = 1'b1; imem_rsp_data = BAD;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        check("c_flush_idv", {31'h0, id_valid}, 32'h0);
        issue("c_tgt", 32'h40);
        respond(32'h0060_0093);
        check("c_new_pc", id_pc, 32'h40);
        check("c_new_inst", id_inst, 32'h0060_0093);

        // Redirect from IDLE with IF/ID full, using a misaligned target.
        do_reset();
        id_ready = 1'b0;
        issue("d0", 32'h0);
        respond(32'h0070_0093);
        check("d_full_idv", {31'h0, id_valid}, 32'h1);
        @(negedge clk);
        #1;
        check("d_stall_noreq", {31'h0, imem_req_valid}, 32'h0);
        check("d_stall_inst", id_inst, 32'h0070_0093);
        redirect_valid = 1'b1; redirect_pc = 32'h302;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("d_flush_idv", {31'h0, id_valid}, 32'h0);
`ifdef FETCH_MISALIGN_EN
        check("d_misalign_set", {31'h0, fetch_misalign}, 32'h1);
        check("d_err_noreq", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("d_err_noreq2", {31'h0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("d_misalign_clr", {31'h0, fetch_misalign}, 32'h0);
`endif
        issue("d_tgt", 32'h300);

        // Redirect in REQ without acceptance, then PC wrap at the top of the address space.
        do_reset();
        id_ready = 1'b1;
        issue("e0", 32'h0);
        respond(32'h0080_0093);
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
        @(negedge clk);
        redirect_valid = 1'b0;
        issue("e_top", 32'hffff_fffc);
        respond(32'h0090_0093);
        check("e_top_pc", id_pc, 32'hffff_fffc);
        check("e_top_inst", id_inst, 32'h0090_0093);
        issue("e_wrap", 32'h0);

        // Reset mid-transaction: a late response is ignored.
        do_reset();
        id_ready = 1'b1;
        issue("f0", 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("f_rst_req", {31'h0, imem_req_valid}, 32'h0);
        check("f_rst_idv", {31'h0, id_valid}, 32'h0);
        check("f_rst_inst", id_inst, NOP);
        respond(BAD);
        check("f_late_idv", {31'h0, id_valid}, 32'h0);
        check("f_late_inst", id_inst, NOP);
        issue("f_again", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
